// File: rtl/rbz_spi_host.sv
// SPI mode-0 write-only initiator for the raybox-zero register and vector ports.
// One MSB-first frame of programmable length in flight; each phase lasts CLK_DIV cycles.
module rbz_spi_host #(
    parameter int unsigned MAX_BITS = 144,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic                          i_target,
    input  logic [$clog2(MAX_BITS+1)-1:0] i_len,
    input  logic [MAX_BITS-1:0]           i_data,
    input  logic                          i_abort,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_reg_csb,
    output logic                          o_reg_sclk,
    output logic                          o_reg_mosi,
    output logic                          o_vec_csb,
    output logic                          o_vec_sclk,
    output logic                          o_vec_mosi
);
    localparam int unsigned LenW = $clog2(MAX_BITS + 1);
    localparam int unsigned PhW  = $clog2(CLK_DIV + 1);
    localparam logic [PhW-1:0]  PhLast = PhW'(CLK_DIV - 1);
    localparam logic [LenW-1:0] LenMax = LenW'(MAX_BITS);

    typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StHold, StGap} state_e;

    state_e                state_q;
    logic [PhW-1:0]        phase_q;
    logic [LenW-1:0]       cnt_q;
    logic [MAX_BITS-1:0]   data_q;
    logic                  target_q;
    logic                  ready_q, busy_q, done_q;
    logic                  csb_q, sclk_q, mosi_q;

    logic [LenW-1:0]       len_clamp;
    logic [LenW-1:0]       first_idx;
    logic [LenW-1:0]       next_idx;
    logic [PhW-1:0]        phase_inc;
    logic                  phase_last;
    logic                  in_frame;

    always_comb begin
        len_clamp  = (i_len > LenMax) ? LenMax : i_len;
        first_idx  = len_clamp - LenW'(1);
        // cnt_q counts bits still to send including the one on the wire now
        next_idx   = cnt_q - LenW'(2);
        phase_inc  = phase_q + PhW'(1);
        phase_last = (phase_q == PhLast);
        in_frame   = (state_q == StSetup) || (state_q == StHigh) ||
                     (state_q == StLow) || (state_q == StHold);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            target_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            csb_q    <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_abort && in_frame) begin
                state_q <= StGap;
                phase_q <= '0;
                csb_q   <= 1'b1;
                sclk_q  <= 1'b0;
                mosi_q  <= 1'b0;
                done_q  <= (PhLast == '0);
            end else if (state_q == StIdle) begin
                if (i_valid) begin
                    target_q <= i_target;
                    data_q   <= i_data;
                    cnt_q    <= len_clamp;
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b1;
                    if (len_clamp == '0) begin
                        // Empty frame: jump to the final gap cycle without touching CSB
                        state_q <= StGap;
                        phase_q <= PhLast;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StSetup;
                        phase_q <= '0;
                        csb_q   <= 1'b0;
                        mosi_q  <= i_data[first_idx];
                    end
                end
            end else if (!phase_last) begin
                phase_q <= phase_inc;
                done_q  <= (state_q == StGap) && (phase_inc == PhLast);
            end else begin
                phase_q <= '0;
                case (state_q)
                    StSetup: begin
                        state_q <= StHigh;
                        sclk_q  <= 1'b1;
                    end
                    StHigh: begin
                        sclk_q <= 1'b0;
                        if (cnt_q == LenW'(1)) begin
                            state_q <= StHold;
                        end else begin
                            state_q <= StLow;
                            cnt_q   <= cnt_q - LenW'(1);
                            mosi_q  <= data_q[next_idx];
                        end
                    end
                    StLow: begin
                        state_q <= StHigh;
                        sclk_q  <= 1'b1;
                    end
                    StHold: begin
                        state_q <= StGap;
                        csb_q   <= 1'b1;
                        mosi_q  <= 1'b0;
                        done_q  <= (PhLast == '0);
                    end
                    StGap: begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign o_ready    = ready_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_reg_csb  = target_q | csb_q;
    assign o_reg_sclk = ~target_q & sclk_q;
    assign o_reg_mosi = ~target_q & mosi_q;
    assign o_vec_csb  = ~target_q | csb_q;
    assign o_vec_sclk = target_q & sclk_q;
    assign o_vec_mosi = target_q & mosi_q;

endmodule

// File: tb/tb_rbz_spi_host.sv
// Bench for rbz_spi_host: two instances (CLK_DIV=2 and CLK_DIV=1) driven by a frame table
// plus directed abort, mid-frame reset and back-to-back sequences.
module tb_rbz_spi_host;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_a, valid_b, target, abort;
    logic [7:0]   len;
    logic [143:0] data;

    logic ready_a, busy_a, done_a, rcsb_a, rsclk_a, rmosi_a, vcsb_a, vsclk_a, vmosi_a;
    logic ready_b, busy_b, done_b, rcsb_b, rsclk_b, rmosi_b, vcsb_b, vsclk_b, vmosi_b;
    logic [8:0] obs_a, obs_b;

    always #5 clk = ~clk;

    rbz_spi_host #(.MAX_BITS(144), .CLK_DIV(2)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid_a), .o_ready(ready_a),
        .i_target(target), .i_len(len), .i_data(data), .i_abort(abort),
        .o_busy(busy_a), .o_done(done_a),
        .o_reg_csb(rcsb_a), .o_reg_sclk(rsclk_a), .o_reg_mosi(rmosi_a),
        .o_vec_csb(vcsb_a), .o_vec_sclk(vsclk_a), .o_vec_mosi(vmosi_a)
    );

    rbz_spi_host #(.MAX_BITS(144), .CLK_DIV(1)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid_b), .o_ready(ready_b),
        .i_target(target), .i_len(len), .i_data(data), .i_abort(abort),
        .o_busy(busy_b), .o_done(done_b),
        .o_reg_csb(rcsb_b), .o_reg_sclk(rsclk_b), .o_reg_mosi(rmosi_b),
        .o_vec_csb(vcsb_b), .o_vec_sclk(vsclk_b), .o_vec_mosi(vmosi_b)
    );

    // {ready, busy, done, reg csb/sclk/mosi, vec csb/sclk/mosi}
    assign obs_a = {ready_a, busy_a, done_a, rcsb_a, rsclk_a, rmosi_a, vcsb_a, vsclk_a, vmosi_a};
    assign obs_b = {ready_b, busy_b, done_b, rcsb_b, rsclk_b, rmosi_b, vcsb_b, vsclk_b, vmosi_b};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit           b;
        logic         tgt;
        logic [7:0]   len;
        logic [143:0] data;
        int           first;
        int           last;
        int           rises;
        int           rise0;
        int           done_c;
        logic [143:0] dec;
    } vec_t;

    vec_t tv[9];

    // Send one frame and observe it cycle by cycle (cycle 1 = first cycle after accept).
    task automatic run_frame(input bit b, input logic tgt, input logic [7:0] n,
                             input logic [143:0] d, output int first, output int last,
                             output int rises, output int rise0, output int done_c,
                             output int ready_c, output int idle_err, output int busy_err,
                             output logic [143:0] dec);
        logic [8:0] o;
        logic [2:0] p;
        logic       prev;
        first = -1; last = -1; rises = 0; rise0 = -1; done_c = -1; ready_c = -1;
        idle_err = 0; busy_err = 0; dec = '0; prev = 1'b0;
        for (int i = 0; i < 1000 && !(b ? ready_b : ready_a); i++) @(negedge clk);
        target = tgt; len = n; data = d;
        if (b) valid_b = 1'b1; else valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0; valid_b = 1'b0;
        target = ~tgt; len = 8'd7; data = ~d;
        for (int c = 1; c <= 700; c++) begin
            if (c > 1) @(negedge clk);
            o = b ? obs_b : obs_a;
            p = tgt ? o[2:0] : o[5:3];
            if ((tgt ? o[5:3] : o[2:0]) !== 3'b100) idle_err++;
            if (o[7] !== ~o[8]) busy_err++;
            if (p[2] === 1'b0) begin
                if (first < 0) first = c;
                last = c;
            end
            if (p[1] && !prev) begin
                rises++;
                if (rise0 < 0) rise0 = c;
                dec = {dec[142:0], p[0]};
            end
            prev = p[1];
            if (o[6] && done_c < 0) done_c = c;
            if (o[8]) begin
                ready_c = c;
                break;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, last, rises, rise0, done_c, ready_c, idle_err, busy_err;
        int abort_c, rdy_first, vfirst, rlast, done1, done2, rr, rv, dcnt, rcnt;
        logic [143:0] dec, dr, dv;
        logic prev, prev_v;

        tv[0] = '{1'b0, 1'b0, 8'd4,   144'hA,      1,  18,   4,  3,  20, 144'hA};
        tv[1] = '{1'b1, 1'b1, 8'd144, {36{4'h5}},  1, 289, 144,  2, 290, {36{4'h5}}};
        tv[2] = '{1'b0, 1'b0, 8'd0,   144'hFFFF,  -1,  -1,   0, -1,   1, 144'h0};
        tv[3] = '{1'b0, 1'b1, 8'd200, {9{16'hC3A5}}, 1, 578, 144, 3, 580, {9{16'hC3A5}}};
        tv[4] = '{1'b0, 1'b1, 8'd1,   144'h1,      1,   6,   1,  3,   8, 144'h1};
        tv[5] = '{1'b1, 1'b0, 8'd3,   144'h6,      1,   7,   3,  2,   8, 144'h6};
        tv[6] = '{1'b0, 1'b1, 8'd16,  144'hBEEF,   1,  66,  16,  3,  68, 144'hBEEF};
        tv[7] = '{1'b1, 1'b0, 8'd0,   144'h3,     -1,  -1,   0, -1,   1, 144'h0};
        tv[8] = '{1'b0, 1'b0, 8'd5,   144'hFFE5,   1,  22,   5,  3,  24, 144'h5};

        rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; target = 1'b0; abort = 1'b0;
        len = '0; data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_a", obs_a, 9'b100_100_100);
        chk("reset_b", obs_b, 9'b100_100_100);

        for (int i = 0; i < 9; i++) begin
            run_frame(tv[i].b, tv[i].tgt, tv[i].len, tv[i].data, first, last, rises, rise0,
                      done_c, ready_c, idle_err, busy_err, dec);
            chk($sformatf("v%0d_csb_first", i), first, tv[i].first);
            chk($sformatf("v%0d_csb_last", i), last, tv[i].last);
            chk($sformatf("v%0d_rises", i), rises, tv[i].rises);
            chk($sformatf("v%0d_rise0", i), rise0, tv[i].rise0);
            chk($sformatf("v%0d_done", i), done_c, tv[i].done_c);
            chk($sformatf("v%0d_ready", i), ready_c, tv[i].done_c + 1);
            chk($sformatf("v%0d_other_idle", i), idle_err, 0);
            chk($sformatf("v%0d_busy_ready", i), busy_err, 0);
            chk($sformatf("v%0d_payload", i), dec, tv[i].dec);
        end

        // Abort after the 3rd rise; abort stays high into the first gap cycle and is ignored there
        @(negedge clk);
        target = 1'b0; len = 8'd8; data = 144'hA5; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        rises = 0; prev = 1'b0; done_c = -1; ready_c = -1; abort_c = -1; dec = '0;
        for (int c = 1; c <= 100; c++) begin
            if (c > 1) @(negedge clk);
            if (abort_c > 0 && c == abort_c + 1)
                chk("abort_spi_idle", {rcsb_a, rsclk_a, rmosi_a}, 3'b100);
            if (abort_c > 0 && c == abort_c + 2) abort = 1'b0;
            if (rsclk_a && !prev) begin
                rises++;
                dec = {dec[142:0], rmosi_a};
                if (rises == 3 && abort_c < 0) begin
                    abort = 1'b1;
                    abort_c = c;
                end
            end
            prev = rsclk_a;
            if (done_a && done_c < 0) done_c = c;
            if (ready_a) begin
                ready_c = c;
                break;
            end
        end
        abort = 1'b0;
        chk("abort_at", abort_c, 11);
        chk("abort_rises", rises, 3);
        chk("abort_bits", dec, 144'h5);
        chk("abort_done", done_c, 13);
        chk("abort_ready", ready_c, 14);

        // Reset mid-frame
        @(negedge clk);
        target = 1'b1; len = 8'd16; data = 144'h1234; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", obs_a, 9'b100_100_100);
        rst_n = 1'b1;
        dcnt = 0; rcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_a) dcnt++;
            if (!ready_a || vcsb_a !== 1'b1) rcnt++;
        end
        chk("midreset_no_done", dcnt, 0);
        chk("midreset_stays_idle", rcnt, 0);
        run_frame(1'b0, 1'b0, 8'd4, 144'hA, first, last, rises, rise0, done_c, ready_c,
                  idle_err, busy_err, dec);
        chk("postreset_payload", dec, 144'hA);
        chk("postreset_done", done_c, 20);

        // Back-to-back with i_valid held high across both frames
        @(negedge clk);
        target = 1'b0; len = 8'd2; data = 144'h2; valid_a = 1'b1;
        @(negedge clk);
        target = 1'b1; len = 8'd3; data = 144'h3;
        rr = 0; rv = 0; dr = '0; dv = '0; prev = 1'b0; prev_v = 1'b0;
        rdy_first = -1; vfirst = -1; rlast = -1; done1 = -1; done2 = -1; ready_c = -1;
        for (int c = 1; c <= 100; c++) begin
            if (c > 1) @(negedge clk);
            if (rdy_first > 0 && c == rdy_first + 1) valid_a = 1'b0;
            if (rcsb_a === 1'b0) rlast = c;
            if (vcsb_a === 1'b0 && vfirst < 0) vfirst = c;
            if (rsclk_a && !prev) begin rr++; dr = {dr[142:0], rmosi_a}; end
            if (vsclk_a && !prev_v) begin rv++; dv = {dv[142:0], vmosi_a}; end
            prev = rsclk_a; prev_v = vsclk_a;
            if (done_a) begin
                if (done1 < 0) done1 = c;
                else if (done2 < 0) done2 = c;
            end
            if (ready_a) begin
                if (rdy_first < 0) rdy_first = c;
                else begin
                    ready_c = c;
                    break;
                end
            end
        end
        valid_a = 1'b0;
        chk("b2b_first_ready", rdy_first, 13);
        chk("b2b_reg_last_low", rlast, 10);
        chk("b2b_vec_first_low", vfirst, 14);
        chk("b2b_gap_ge_d", (vfirst - rlast - 1) >= 2, 1'b1);
        chk("b2b_reg_rises", rr, 2);
        chk("b2b_reg_payload", dr, 144'h2);
        chk("b2b_vec_rises", rv, 3);
        chk("b2b_vec_payload", dv, 144'h3);
        chk("b2b_done1", done1, 12);
        chk("b2b_done2", done2, 29);
        chk("b2b_final_ready", ready_c, 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
